// File: rtl/led_code_scheduler.sv
// Round-robin owner of a single status LED: each granted requester gets its
// blink code played (CODE pulses, then a dark gap), followed by a 1-cycle ack.
module led_code_scheduler #(
    parameter int NUM_REQ   = 4,
    parameter int CODE_W    = 4,
    parameter int TICK_DIV  = 16_000_000,
    parameter int GAP_TICKS = 6
) (
    input  logic                        clk_128M,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*CODE_W-1:0]   code,
    output logic [NUM_REQ-1:0]          ack,
    output logic                        busy,
    output logic [$clog2(NUM_REQ)-1:0]  grant_id,
    output logic                        led
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int PW = $clog2(TICK_DIV);
    localparam int GW = $clog2(GAP_TICKS + 1);
    localparam logic [PW-1:0] PS_LAST  = PW'(TICK_DIV - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_TICKS - 1);

    typedef enum logic [2:0] {S_IDLE, S_ON, S_OFF, S_GAP, S_DONE} state_t;

    state_t              r_state, w_state_nxt;
    logic [PW-1:0]       r_ps;
    logic [GW-1:0]       r_gap;
    logic [CODE_W-1:0]   r_cnt;
    logic [IW-1:0]       r_ptr;
    logic [IW-1:0]       r_grant_id;
    logic [NUM_REQ-1:0]  r_ack;
    logic                r_busy;
    logic                r_led;

    logic [CODE_W-1:0]   w_codes [NUM_REQ];
    logic [IW-1:0]       w_pick;
    logic [IW-1:0]       w_ack_id;
    logic                w_any;
    logic                w_tick_end;
    logic                w_gap_end;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_code
        assign w_codes[g] = code[g*CODE_W +: CODE_W];
    end

    // First requester after the last granted one, wrapping around.
    function automatic logic [IW-1:0] f_rr_pick(input logic [NUM_REQ-1:0] r,
                                                input logic [IW-1:0] p);
        logic [IW-1:0] sel;
        logic [IW-1:0] k;
        logic          found;
        sel   = '0;
        found = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            k = IW'((int'(p) + i) % NUM_REQ);
            if (!found && r[k]) begin
                found = 1'b1;
                sel   = k;
            end
        end
        return sel;
    endfunction

    assign w_pick     = f_rr_pick(req, r_ptr);
    assign w_any      = |req;
    assign w_tick_end = (r_ps == PS_LAST);
    assign w_gap_end  = (r_gap == GAP_LAST);
    // A zero-length code goes straight to DONE, so the ack target is the new pick.
    assign w_ack_id   = (r_state == S_IDLE) ? w_pick : r_grant_id;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_any) w_state_nxt = (w_codes[w_pick] != '0) ? S_ON : S_DONE;
            S_ON:   if (w_tick_end) w_state_nxt = S_OFF;
            S_OFF:  if (w_tick_end) w_state_nxt = (r_cnt != '0) ? S_ON : S_GAP;
            S_GAP:  if (w_tick_end && w_gap_end) w_state_nxt = S_DONE;
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_128M or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Outputs are registered from the next state so the LED and ack line up
    // with the state they belong to.
    always_ff @(posedge clk_128M or posedge rst) begin
        if (rst) begin
            r_ps       <= '0;
            r_gap      <= '0;
            r_cnt      <= '0;
            r_ptr      <= IW'(NUM_REQ - 1);
            r_grant_id <= '0;
            r_ack      <= '0;
            r_busy     <= 1'b0;
            r_led      <= 1'b0;
        end else begin
            r_led  <= (w_state_nxt == S_ON);
            r_busy <= (w_state_nxt != S_IDLE);
            r_ack  <= '0;
            if (w_state_nxt == S_DONE) r_ack[w_ack_id] <= 1'b1;

            if (w_state_nxt != r_state)
                r_ps <= '0;
            else if (r_state == S_ON || r_state == S_OFF || r_state == S_GAP)
                r_ps <= w_tick_end ? '0 : r_ps + 1'b1;

            if (w_state_nxt != S_GAP)
                r_gap <= '0;
            else if (r_state == S_GAP && w_tick_end)
                r_gap <= r_gap + 1'b1;

            if (r_state == S_IDLE && w_any) begin
                r_cnt      <= w_codes[w_pick];
                r_grant_id <= w_pick;
                r_ptr      <= w_pick;
            end else if (r_state == S_ON && w_tick_end) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    assign ack      = r_ack;
    assign busy     = r_busy;
    assign grant_id = r_grant_id;
    assign led      = r_led;

endmodule

// File: tb/tb_led_code_scheduler.sv
// Bench for led_code_scheduler: a schedule-based reference model (grant time,
// code length, phase offset) is compared against the DUT every cycle.
module tb_led_code_scheduler;
    localparam int NR = 4;
    localparam int CW = 4;
    localparam int TD = 4;
    localparam int GT = 2;

    logic              clk_128M = 1'b0;
    logic              rst = 1'b0;
    logic              clk_en = 1'b0;
    logic [NR-1:0]     req = '0;
    logic [NR*CW-1:0]  code = '0;
    logic [NR-1:0]     ack;
    logic              busy;
    logic [1:0]        grant_id;
    logic              led;

    led_code_scheduler #(.NUM_REQ(NR), .CODE_W(CW), .TICK_DIV(TD), .GAP_TICKS(GT)) dut (
        .clk_128M(clk_128M), .rst(rst), .req(req), .code(code),
        .ack(ack), .busy(busy), .grant_id(grant_id), .led(led)
    );

    initial begin
        wait (clk_en);
        forever #5 clk_128M = ~clk_128M;
    end

    // Model: a sequence is "active" from G+1; m_d is the offset into it and
    // m_len the offset of its ack cycle.
    bit m_active = 1'b0;
    int m_d = 0, m_len = 0, m_n = 0, m_id = 0, m_ptr = NR - 1;

    always @(posedge clk_128M or posedge rst) begin
        if (rst) begin
            m_active = 1'b0; m_d = 0; m_len = 0; m_n = 0; m_id = 0; m_ptr = NR - 1;
        end else if (m_active && m_d < m_len) begin
            m_d = m_d + 1;
        end else if (m_active) begin
            m_active = 1'b0;
        end else if (req != '0) begin
            bit found;
            int k;
            found = 1'b0;
            for (int i = 1; i <= NR; i++) begin
                k = (m_ptr + i) % NR;
                if (!found && req[k[1:0]]) begin
                    found = 1'b1;
                    m_id = k;
                end
            end
            m_ptr = m_id;
            m_n = int'(code[m_id*CW +: CW]);
            m_len = (m_n == 0) ? 0 : (2 * m_n + GT) * TD;
            m_d = 0;
            m_active = 1'b1;
        end
    end

    int n_chk = 0, n_pass = 0, cyc = 0;
    logic          e_led, e_busy;
    logic [NR-1:0] e_ack;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    task automatic step();
        @(negedge clk_128M);
        cyc++;
        e_busy = m_active;
        e_led  = m_active && (m_d < 2 * m_n * TD) && ((m_d / TD) % 2 == 0);
        e_ack  = '0;
        if (m_active && m_d == m_len) e_ack[m_id[1:0]] = 1'b1;
        chk("led", 32'(led), 32'(e_led));
        chk("busy", 32'(busy), 32'(e_busy));
        chk("ack", 32'(ack), 32'(e_ack));
        chk("grant_id", 32'(grant_id), 32'(m_id));
    endtask

    task automatic wait_busy(output int g);
        g = cyc;
        for (int k = 0; k < 200; k++) begin
            step();
            if (busy) begin
                g = cyc - 1;
                return;
            end
        end
        n_chk++;
        $display("FAIL wait_busy: busy still 0, required 1 within 200 cycles");
    endtask

    task automatic run_to_ack(output int nled);
        nled = 0;
        for (int k = 0; k < 300; k++) begin
            if (led) nled++;
            if (ack != '0) return;
            step();
        end
        n_chk++;
        $display("FAIL wait_ack: ack still 0, required nonzero within 300 cycles");
    endtask

    int g, nled, nack, ngr;
    int gr [4];
    int gc [4];
    int lat [4];
    bit reraised, prev_busy;

    initial begin
        // Reset with the clock stopped.
        #2 rst = 1'b1;
        #1;
        chk("rst_led", 32'(led), 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_gid", 32'(grant_id), 0);
        clk_en = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        step();

        // Code 3 on requester 2.
        code = 16'h0300; req = 4'b0100;
        wait_busy(g);
        run_to_ack(nled);
        chk("t2_ack_cycle", cyc - g, 33);
        chk("t2_ack", 32'(ack), 4);
        chk("t2_gid", 32'(grant_id), 2);
        chk("t2_led_cycles", nled, 12);
        req = '0;
        step();
        chk("t2_busy_low", 32'(busy), 0);
        step();

        // Round robin from reset with all codes = 1.
        rst = 1'b1; step(); rst = 1'b0; step();
        code = 16'h1111; req = 4'b1011;
        ngr = 0; reraised = 1'b0; prev_busy = busy;
        for (int i = 0; i < 4; i++) begin gr[i] = -1; gc[i] = 0; lat[i] = -1; end
        for (int k = 0; k < 300; k++) begin
            step();
            if (busy && !prev_busy && ngr < 4) begin
                gr[ngr] = int'(grant_id); gc[ngr] = cyc - 1; ngr++;
            end
            if (ack != '0 && ngr > 0) begin
                lat[ngr-1] = cyc - gc[ngr-1];
                req = req & ~ack;
                if (ack == 4'b0001 && !reraised) begin req[0] = 1'b1; reraised = 1'b1; end
                if (ngr == 4) break;
            end
            prev_busy = busy;
        end
        chk("t3_grant0", gr[0], 0);
        chk("t3_grant1", gr[1], 1);
        chk("t3_grant2", gr[2], 3);
        chk("t3_grant3", gr[3], 0);
        for (int i = 0; i < 4; i++) chk("t3_ack_latency", lat[i], 17);
        req = '0;
        repeat (2) step();

        // Zero-length code.
        code = 16'h0000; req = 4'b0010;
        wait_busy(g);
        chk("t4_ack", 32'(ack), 2);
        chk("t4_led", 32'(led), 0);
        chk("t4_gid", 32'(grant_id), 1);
        req = '0;
        step();
        chk("t4_busy_1cyc", 32'(busy), 0);
        step();

        // Reset in the second ON phase.
        code = 16'h0003; req = 4'b0001;
        wait_busy(g);
        while (cyc < g + 10) step();
        chk("t5_led_on2", 32'(led), 1);
        rst = 1'b1;
        #1;
        chk("t5_rst_led", 32'(led), 0);
        chk("t5_rst_busy", 32'(busy), 0);
        chk("t5_rst_ack", 32'(ack), 0);
        req = '0;
        step();
        rst = 1'b0;
        nack = 0;
        repeat (40) begin step(); if (ack != '0) nack++; end
        chk("t5_no_ack", nack, 0);
        code = 16'h0010; req = 4'b1010;
        wait_busy(g);
        chk("t5_first_gid", 32'(grant_id), 1);
        run_to_ack(nled);
        req = '0;
        repeat (2) step();

        // Drop req and change code mid-sequence.
        code = 16'h0002; req = 4'b0001;
        wait_busy(g);
        nled = 0;
        for (int k = 0; k < 200; k++) begin
            if (led) nled++;
            if (ack != '0) break;
            if (k == 3) begin req = '0; code = 16'h0007; end
            step();
        end
        chk("t6_ack_cycle", cyc - g, 25);
        chk("t6_ack", 32'(ack), 1);
        chk("t6_led_cycles", nled, 8);
        repeat (2) step();

        // Random traffic: requests retire on ack, codes churn, rare resets.
        for (int n = 0; n < 2500; n++) begin
            step();
            req = req & ~e_ack;
            if ($urandom_range(0, 9) == 0) req = req | NR'($urandom);
            if ($urandom_range(0, 60) == 0) req = req & ~NR'(1 << $urandom_range(0, 3));
            for (int i = 0; i < NR; i++) code[i*CW +: CW] = CW'($urandom_range(0, 4));
            if (rst) rst = 1'b0;
            else if ($urandom_range(0, 800) == 0) rst = 1'b1;
        end
        rst = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
